// File: rtl/case_sel_pipe_if.sv
// Valid/ready bus for case_sel_pipe: multi-channel input beat in, one selected channel out.
// The master drives the input side and consumes the output side; the slave is the pipeline.
interface case_sel_pipe_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [SELW-1:0]      sel;
    logic                 scan_en;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_default;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, sel, scan_en, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_default, out_valid
    );

    modport slave (
        input  in_data, sel, scan_en, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_default, out_valid
    );
endinterface

// File: rtl/case_sel_pipe.sv
// Registered channel selector with one skid entry and an auto-scan select counter.
// Define CASE_SEL_HOLD_LAST_EN to output the last in-range data on out-of-range selects.
module case_sel_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      NCH     = 4,
    parameter int unsigned      SELW    = 2,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input logic            clk,
    input logic            rst,
    case_sel_pipe_if.slave bus
);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic             accept;
    logic [SELW-1:0]  esel;
    logic             in_range;
    logic [WIDTH-1:0] dec_data;
    logic [WIDTH-1:0] miss_data;
    logic [SELW-1:0]  scan_cnt_q;

    logic [WIDTH-1:0] out_data_q, skid_data_q;
    logic [SELW-1:0]  out_ch_q, skid_ch_q;
    logic             out_dflt_q, skid_dflt_q;
    logic             out_valid_q, skid_valid_q;

    assign bus.in_ready = !skid_valid_q && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign esel         = bus.scan_en ? scan_cnt_q : bus.sel;
    assign in_range     = 32'(esel) < NCH;

`ifdef CASE_SEL_HOLD_LAST_EN
    logic [WIDTH-1:0] hold_q;

    // Tracks the newest accepted in-range beat; beat order makes it the last one output.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= DEFAULT;
        end else if (accept && in_range) begin
            hold_q <= dec_data;
        end
    end

    assign miss_data = hold_q;
`else
    assign miss_data = DEFAULT;
`endif

    // Unused select codes never match a channel, so they fall through to miss_data.
    always_comb begin
        dec_data = miss_data;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (esel == SELW'(k)) begin
                dec_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.scan_en) begin
            scan_cnt_q <= '0;
        end else if (accept) begin
            scan_cnt_q <= (scan_cnt_q == LAST_CH) ? '0 : scan_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_dflt_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ch_q    <= '0;
            skid_dflt_q  <= 1'b0;
        end else begin
            if (!out_valid_q || bus.out_ready) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_ch_q     <= skid_ch_q;
                    out_dflt_q   <= skid_dflt_q;
                    skid_valid_q <= 1'b0;
                end else if (accept) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= dec_data;
                    out_ch_q    <= esel;
                    out_dflt_q  <= !in_range;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
            // accept implies an empty skid, so this never collides with the unload above.
            if (accept && out_valid_q && !bus.out_ready) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= dec_data;
                skid_ch_q    <= esel;
                skid_dflt_q  <= !in_range;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_ch      = out_ch_q;
    assign bus.out_default = out_dflt_q;
endmodule

// File: tb/tb_case_sel_pipe.sv
// Self-checking bench for case_sel_pipe (WIDTH=8, NCH=3, SELW=2, DEFAULT=0xA5).
// A negedge monitor models accepts into a scoreboard and checks every popped beat.
module tb_case_sel_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NCH   = 3;
    localparam int unsigned SELW  = 2;
    localparam logic [7:0]  DFLT  = 8'hA5;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
        logic       dflt;
    } beat_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    beat_t sb[$];
    logic [1:0] m_cnt;
    logic [7:0] m_hold;

    case_sel_pipe_if #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) bus ();

    case_sel_pipe #(
        .WIDTH  (WIDTH),
        .NCH    (NCH),
        .SELW   (SELW),
        .DEFAULT(DFLT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pop check first, then record a beat accepted at the coming edge.
    always @(negedge clk) begin
        beat_t exp;
        beat_t got;
        int    esel;
        if (rst) begin
            sb.delete();
            m_cnt  = 2'd0;
            m_hold = DFLT;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                got = '{data: bus.out_data, ch: bus.out_ch, dflt: bus.out_default};
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_unexpected: got %h, required no beat", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL scoreboard_beat: got data=%h ch=%0d dflt=%b, required data=%h ch=%0d dflt=%b",
                                 got.data, got.ch, got.dflt, exp.data, exp.ch, exp.dflt);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                esel = bus.scan_en ? int'(m_cnt) : int'(bus.sel);
                if (esel < NCH) begin
                    exp.data = bus.in_data[esel*8 +: 8];
                    exp.dflt = 1'b0;
                    m_hold   = exp.data;
                end else begin
`ifdef CASE_SEL_HOLD_LAST_EN
                    exp.data = m_hold;
`else
                    exp.data = DFLT;
`endif
                    exp.dflt = 1'b1;
                end
                exp.ch = 2'(esel);
                sb.push_back(exp);
            end
            if (!bus.scan_en) m_cnt = 2'd0;
            else if (bus.in_valid && bus.in_ready) m_cnt = (m_cnt == 2'd2) ? 2'd0 : m_cnt + 2'd1;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h, required 00", bus.out_data); end
        if (bus.out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch: got %0d, required 0", bus.out_ch); end
        if (bus.out_default !== 1'b0) begin n_fail++; $display("FAIL reset_out_default: got %b, required 0", bus.out_default); end
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b, required 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release: got %b, required 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        bus.in_data = 24'h332211; bus.sel = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, required 1", bus.out_valid); end
        if (bus.out_data !== 8'h33) begin n_fail++; $display("FAIL basic_data: got %h, required 33", bus.out_data); end
        if (bus.out_ch !== 2'd2) begin n_fail++; $display("FAIL basic_ch: got %0d, required 2", bus.out_ch); end
        if (bus.out_default !== 1'b0) begin n_fail++; $display("FAIL basic_default: got %b, required 0", bus.out_default); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] exp_data;
`ifdef CASE_SEL_HOLD_LAST_EN
        exp_data = 8'h22;
`else
        exp_data = DFLT;
`endif
        @(posedge clk); #1;
        bus.sel = 2'd1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.sel = 2'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (bus.out_data !== exp_data) begin n_fail++; $display("FAIL oor_data: got %h, required %h", bus.out_data, exp_data); end
        if (bus.out_default !== 1'b1) begin n_fail++; $display("FAIL oor_default: got %b, required 1", bus.out_default); end
        if (bus.out_ch !== 2'd3) begin n_fail++; $display("FAIL oor_ch: got %0d, required 3", bus.out_ch); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] exp[3];
        logic       acc;
        exp = '{8'h11, 8'h22, 8'h33};
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.sel = 2'd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.sel = 2'd1;
        @(posedge clk); #1;
        bus.sel = 2'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b, required 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid: got %b, required 1", bus.out_valid); end
        if (bus.out_data !== 8'h11) begin n_fail++; $display("FAIL bp_stall_data: got %h, required 11", bus.out_data); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.out_valid) got.push_back(bus.out_data);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) bus.in_valid = 1'b0;
        end
        n_checks++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, required 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h, required %h", i, got[i], exp[i]); end
            end
        end
    endtask

    task automatic test_scan();
        logic [1:0] got[$];
        int         n_acc;
        n_acc = 0;
        @(posedge clk); #1;
        bus.scan_en = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = 24'hC3B2A1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) got.push_back(bus.out_ch);
            if (bus.in_valid && bus.in_ready) n_acc++;
            @(posedge clk); #1;
            if (n_acc == 7) bus.in_valid = 1'b0;
        end
        n_checks++;
        if (got.size() != 7) begin
            n_fail++;
            $display("FAIL scan_count: got %0d beats, required 7", got.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (got[i] !== 2'(i % 3)) begin n_fail++; $display("FAIL scan_ch[%0d]: got %0d, required %0d", i, got[i], i % 3); end
            end
        end
        bus.scan_en = 1'b0;
        @(posedge clk); #1;
        bus.scan_en = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL scan_restart: got ch=%0d valid=%b, required ch=0 valid=1", bus.out_ch, bus.out_valid);
        end
        bus.scan_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pops;
        pops = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_data = 24'($urandom); bus.sel = 2'(c % 4); bus.in_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b, required 1", c, bus.in_ready); end
            if (c > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b, required 1", c, bus.out_valid); end
                else pops++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (bus.out_valid === 1'b1) pops++;
        n_checks++;
        if (pops != 10) begin n_fail++; $display("FAIL b2b_throughput: got %0d beats, required 10", pops); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.sel = 2'd0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.sel = 2'd1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got in_ready=%b, required 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_in_ready_rst: got %b, required 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready_release: got %b, required 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale[%0d]: got valid=%b, required 0", c, bus.out_valid); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.in_data = '0; bus.sel = '0; bus.scan_en = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_out_of_range();
        test_backpressure();
        test_scan();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drained: got %0d pending, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/case_sel_pipe.md
Name: case_sel_pipe

Overview:
- Parametrised, registered successor to the single-bit case-selector function.
- Selects one of NCH channels of WIDTH bits using a case-style decode; out-of-range selects produce a default value.
- Wrapped in a valid/ready pipeline stage with a skid buffer, plus an auto-scan mode that steps through channels on its own.
- Sits between a multi-source data bus and a single-consumer datapath.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NCH, 4, number of input channels (>=1).
- SELW, 2, select width in bits; must satisfy 2**SELW >= NCH.
- DEFAULT, 0, WIDTH-bit value output when the select is out of range.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- SEL  input  SELW  channel select; used only when SCAN_EN=0.
- SCAN_EN  input  1  1 = internal scan counter supplies the select.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  block can accept a beat.
- OUT_DATA  output  WIDTH  selected data.
- OUT_CH  output  SELW  effective select used for this beat.
- OUT_DEFAULT  output  1  beat carries DEFAULT because the select was >= NCH.
- OUT_VALID  output  1  output beat valid.
- OUT_READY  input  1  consumer accepts the beat.

Behaviour:
- accept = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- Effective select: esel = SCAN_EN ? scan_cnt : SEL, sampled in the accept cycle.
- Decode:
  - esel < NCH: data = channel esel, dflt = 0.
  - otherwise: data = DEFAULT, dflt = 1.
  - No X propagation for unused select codes.
- Storage: an output register (OUT_*) and one skid entry (data, ch, dflt, skid_valid).
- IN_READY = !skid_valid & !RST. At most 2 beats are held. Beat order is strictly preserved.
- Output register load: when !OUT_VALID | OUT_READY:
  - skid_valid: load from skid, clear skid_valid.
  - else if accept: load the decoded input beat.
  - else: OUT_VALID <= 0.
- Skid capture: when accept and the output register is occupied and not popping (OUT_VALID & !OUT_READY), store the beat in the skid and set skid_valid.
- Latency: accept in cycle N -> OUT_VALID in cycle N+1 when no stall. Throughput is 1 beat/cycle with OUT_READY held at 1.
- Full condition: skid_valid=1 -> IN_READY=0. It returns to 1 the cycle after the stalled output pops.
- Simultaneous accept and pop with an empty skid: the new beat goes straight to the output register; the skid is not used.
- OUT_* are stable while OUT_VALID & !OUT_READY.
- Scan counter (SELW bits):
  - Increments on each accept while SCAN_EN=1; wraps NCH-1 -> 0.
  - Cleared to 0 in any cycle with SCAN_EN=0.
  - Toggling SCAN_EN affects only beats accepted afterwards.
- Reset (synchronous, RST=1 at a rising edge):
  - OUT_VALID=0, OUT_DATA=0, OUT_CH=0, OUT_DEFAULT=0, skid_valid=0, scan_cnt=0.
  - IN_READY=0 while RST is high, 1 in the first cycle after release.
  - Reset mid-transfer discards all held beats; no partial output.

Optional Feature:
- Macro: CASE_SEL_HOLD_LAST_EN.
- Defined: an out-of-range select outputs the data of the most recently output in-range beat instead of DEFAULT. OUT_DEFAULT is still 1. The held value resets to DEFAULT.
- Undefined: out-of-range select outputs DEFAULT. No hold register is synthesised.

Test Plan:
- Reset then basic select: WIDTH=8, NCH=4, IN_DATA=0x44332211, SEL=2, IN_VALID=1 for one cycle, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0x33, OUT_CH=2, OUT_DEFAULT=0.
- Out of range: NCH=3, SELW=2, DEFAULT=0xA5, SEL=3 -> OUT_DATA=0xA5, OUT_DEFAULT=1. With CASE_SEL_HOLD_LAST_EN and a prior SEL=1 beat of 0x22 -> OUT_DATA=0x22, OUT_DEFAULT=1.
- Backpressure: OUT_READY=0, stream beats SEL=0,1,2 with IN_VALID=1:
  - beat0 in the output register, beat1 in the skid, IN_READY=0, beat2 held off.
  - Raise OUT_READY -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
- Scan mode: SCAN_EN=1, NCH=3, 7 consecutive accepts -> OUT_CH sequence 0,1,2,0,1,2,0. Drop SCAN_EN for one cycle -> next scan beat has OUT_CH=0.
- Simultaneous accept and pop: OUT_VALID=1, OUT_READY=1, IN_VALID=1 every cycle for 10 cycles -> 1 beat/cycle, skid_valid never set, IN_READY constantly 1.
- Reset mid-operation: skid full and output stalled, assert RST for 1 cycle -> OUT_VALID=0, IN_READY=0 during reset, then 1. No stale beat appears after release.
